credit_delay_line: RTL and testbench

Parametrised fixed-latency delay line with admission control by in-flight token count. Accepted tokens (valid + payload) traverse a LATENCY-stage shift pipeline. An occupancy counter increments on entry and decrements on exit, and input readiness is withheld once MAX_INFLIGHT tokens are in flight. This is the generalised successor of the single-bit masked-token/reconvergent-counter test block, used as a formal and reconvergence-analysis benchmark and as a reusable latency-matching stage.

---
 rtl/credit_delay_line_if.sv | 38 +++
 rtl/credit_delay_line.sv | 95 +++++++++
 tb/tb_credit_delay_line.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/credit_delay_line_if.sv
// -----------------------------------------------------------------------------
// credit_delay_line_if
//
// Bundles the token handshake of credit_delay_line: the upstream token
// (in_valid/in_data) with its admission signal (in_ready), the synchronous
// flush request, the exiting token (out_valid/out_data) and the occupancy count.
//
// Parameters:
//   DATA_W : payload width in bits
//   CNT_W  : occupancy counter width
//
// Modports:
//   master : the upstream/downstream environment; drives in_valid, in_data and
//            flush, and observes in_ready, out_valid, out_data and inflight
//   slave  : the delay line itself
// -----------------------------------------------------------------------------
interface credit_delay_line_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  inflight;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, out_valid, out_data, inflight
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, out_valid, out_data, inflight
    );
endinterface

// File: rtl/credit_delay_line.sv
// -----------------------------------------------------------------------------
// credit_delay_line
//
// Fixed-latency delay line with admission control. A token accepted in cycle t
// (in_valid & in_ready) leaves on out_valid/out_data in cycle t+LATENCY for one
// cycle. An occupancy counter tracks tokens in flight; in_ready is withheld
// while MAX_INFLIGHT tokens are in flight. The output has no backpressure.
//
// Parameters:
//   DATA_W       : payload width (>=1)
//   LATENCY      : pipeline stages from accept to output (>=1)
//   MAX_INFLIGHT : admission limit (1 .. 2**CNT_W-1)
//   CNT_W        : counter width, 2**CNT_W-1 >= LATENCY
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-low reset, released synchronously to clk
//   bus : credit_delay_line_if.slave
//           in_valid/in_data  upstream token
//           in_ready          admission (combinational from the count)
//           flush             synchronous clear of pipeline and counter
//           out_valid/out_data exiting token, data is 0 on bubbles
//           inflight          current occupancy count
//
// Optional feature macro: CREDIT_DELAY_EARLY_CREDIT_EN
//   When defined, a slot freed by a token exiting this cycle can be reused in
//   the same cycle (in_ready looks at count - exit). When undefined, the freed
//   slot becomes usable one cycle after the exit.
// -----------------------------------------------------------------------------
module credit_delay_line #(
    parameter int DATA_W       = 8,
    parameter int LATENCY      = 4,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 3
) (
    input logic                clk,
    input logic                rst,
    credit_delay_line_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [LATENCY-1:0] stage_valid;
    logic [DATA_W-1:0]  stage_data [LATENCY];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               accept;
    logic               exit_tok;

    assign exit_tok = stage_valid[LATENCY-1];

`ifdef CREDIT_DELAY_EARLY_CREDIT_EN
    // An exiting token implies count >= 1, so this subtraction cannot wrap.
    assign bus.in_ready = (count - CNT_W'(exit_tok)) < MAX_CNT;
`else
    assign bus.in_ready = count < MAX_CNT;
`endif

    assign accept = bus.in_valid & bus.in_ready;

    always_comb begin
        // NOTE: assign a default first in every always_comb path so no latch is inferred.
        count_next = count;
        // Truncated arithmetic: +1/-1 together cancel, and the count is bounded
        // by the number of stage valids, so no overflow or underflow occurs.
        count_next = count + CNT_W'(accept) - CNT_W'(exit_tok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data stages are reset too, because bubbles must read as 0 on out_data.
            stage_valid <= '0;
            for (int i = 0; i < LATENCY; i++) stage_data[i] <= '0;
            count <= '0;
        end else if (bus.flush) begin
            // Flush wins over accept/exit; a token accepted this cycle is dropped.
            stage_valid <= '0;
            for (int i = 0; i < LATENCY; i++) stage_data[i] <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
            stage_valid[0] <= accept;
            stage_data[0]  <= accept ? bus.in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
            count <= count_next;
        end
    end

    assign bus.out_valid = stage_valid[LATENCY-1];
    assign bus.out_data  = stage_data[LATENCY-1];
    assign bus.inflight  = count;

endmodule

// File: tb/tb_credit_delay_line.sv
// -----------------------------------------------------------------------------
// tb_credit_delay_line
//
// Bench for credit_delay_line with default parameters. A token-queue model
// (each entry holds its due cycle and payload) predicts in_ready, out_valid,
// out_data and inflight; a negedge process compares the DUT to it every cycle.
// Directed sequences add literal expectations at specific cycles.
// Honours CREDIT_DELAY_EARLY_CREDIT_EN for the expected admission rule.
// -----------------------------------------------------------------------------
module tb_credit_delay_line;
    localparam int DATA_W       = 8;
    localparam int LATENCY      = 4;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    credit_delay_line_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    credit_delay_line #(
        .DATA_W      (DATA_W),
        .LATENCY     (LATENCY),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int unsigned       due;
        logic [DATA_W-1:0] data;
    } tok_t;

    tok_t        q[$];
    int unsigned cyc = 0;

    function automatic logic model_exit();
        return (q.size() > 0) && (q[0].due == cyc);
    endfunction

    function automatic logic model_ready();
        int occ = q.size();
`ifdef CREDIT_DELAY_EARLY_CREDIT_EN
        if (model_exit()) occ--;
`endif
        return occ < MAX_INFLIGHT;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else begin
            logic acc;
            logic ex;
            acc = bus.in_valid && model_ready();
            ex  = model_exit();
            if (bus.flush) begin
                q.delete();
            end else begin
                if (ex) void'(q.pop_front());
                if (acc) q.push_back('{due: cyc + LATENCY, data: bus.in_data});
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic              ev;
            logic [DATA_W-1:0] ed;
            ev = model_exit();
            ed = ev ? q[0].data : '0;
            check("m_in_ready",  32'(bus.in_ready),  32'(model_ready()));
            check("m_out_valid", 32'(bus.out_valid), 32'(ev));
            check("m_out_data",  32'(bus.out_data),  32'(ed));
            check("m_inflight",  32'(bus.inflight),  32'(q.size()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic f);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0);
            tick();
        end
    endtask

    logic [DATA_W-1:0] d;
    logic [19:0]       pat;

    initial begin
        drive(1'b0, '0, 1'b0);
        chk_en = 1'b1;

        // 1: reset for two cycles, then release
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t1_in_ready",  32'(bus.in_ready),  32'd1);
        check("t1_out_valid", 32'(bus.out_valid), 32'd0);
        check("t1_out_data",  32'(bus.out_data),  32'h00);
        check("t1_inflight",  32'(bus.inflight),  32'd0);
        tick();

        // 2: single token 0xA5
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, (c == 0) ? 8'hA5 : 8'h00, 1'b0);
            @(negedge clk);
            check("t2_inflight",  32'(bus.inflight),  (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check("t2_out_valid", 32'(bus.out_valid), (c == 4) ? 32'd1 : 32'd0);
            check("t2_out_data",  32'(bus.out_data),  (c == 4) ? 32'hA5 : 32'h00);
            tick();
        end

        // 3/4: continuous in_valid, payload advances on each accept
        d = 8'h01;
        for (int c = 0; c < 10; c++) begin
            logic [6:0] exp_rdy;
            drive(c < 8, d, 1'b0);
            @(negedge clk);
`ifdef CREDIT_DELAY_EARLY_CREDIT_EN
            exp_rdy = 7'b1110111;   // bit c: cycle 3 only stalls
`else
            exp_rdy = 7'b1100111;   // bit c: cycles 3 and 4 stall
`endif
            if (c < 7) check("t3_in_ready", 32'(bus.in_ready), 32'(exp_rdy[c]));
            if (c >= 4 && c <= 6) begin
                check("t3_out_valid", 32'(bus.out_valid), 32'd1);
                check("t3_out_data",  32'(bus.out_data),  32'(c - 3));
            end
            if (c == 5) begin
`ifdef CREDIT_DELAY_EARLY_CREDIT_EN
                check("t3_inflight_c5", 32'(bus.inflight), 32'd3);
`else
                check("t3_inflight_c5", 32'(bus.inflight), 32'd2);
`endif
            end
            if (bus.in_valid && model_ready()) d++;
            tick();
        end
        idle(LATENCY + 2);
        check("t3_drained", 32'(bus.inflight), 32'd0);

        // 5: three accepts, flush in the third cycle
        for (int c = 0; c < 9; c++) begin
            drive(c <= 2, 8'h10 + 8'(c), c == 2);
            @(negedge clk);
            if (c == 2) check("t5_ready_flush_cycle", 32'(bus.in_ready), 32'd1);
            if (c == 3) check("t5_ready_after", 32'(bus.in_ready), 32'd1);
            if (c >= 3) begin
                check("t5_inflight",  32'(bus.inflight),  32'd0);
                check("t5_out_valid", 32'(bus.out_valid), 32'd0);
            end
            tick();
        end

        // 6: two accepts, asynchronous reset in the middle of cycle 2
        drive(1'b1, 8'h21, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        #2;
        check("t6_pre_inflight", 32'(bus.inflight), 32'd2);
        rst = 1'b0;
        #1;
        check("t6_rst_inflight",  32'(bus.inflight),  32'd0);
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        rst = 1'b1;
        for (int c = 0; c < LATENCY + 2; c++) begin
            @(negedge clk);
            check("t6_no_stale_valid", 32'(bus.out_valid), 32'd0);
            check("t6_no_stale_cnt",   32'(bus.inflight),  32'd0);
            tick();
        end

        // 7: irregular valid pattern with a flush, checked by the model
        pat = 20'b1011_0011_1101_0111_1011;
        for (int c = 0; c < 20; c++) begin
            drive(pat[c], 8'hC0 ^ 8'(c * 7), c == 11);
            tick();
        end
        idle(LATENCY + 2);
        check("t7_drained", 32'(bus.inflight), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
